// File: rtl/gpio_pwm_gen.sv
// -----------------------------------------------------------------------------
// gpio_pwm_gen
//   Two-channel PWM generator feeding the GPIO pin-mux stage.
//   pwm_out_a drives data_in[9], pwm_out_b drives data_in[8]; EN_PWM_OUTA0 and
//   EN_PWM_OUTB0 drive the mux enables of the same names.
//
//   PERIOD / CMP_A / CMP_B (and DEADTIME when present) are double-buffered:
//   register writes land in a shadow copy that moves to the active copy at
//   the counter wrap, or every cycle while stopped, so a running PWM cycle
//   never glitches. A write in the wrap cycle is forwarded straight into the
//   active copy.
//
//   Optional feature macro: GPIO_PWM_DEADTIME_EN
//     Adds DEADTIME at address 4 and CTRL[5] (comp). With comp=1 channel B is
//     the complement of A, and every change of raw A blanks both channels for
//     DEADTIME cycles (restarting on a further change).
//
// Ports
//   clk           system clock
//   rst_n         synchronous reset, active low
//   wr_en         register write strobe (1 cycle)
//   addr[2:0]     register address for write and readback
//   wr_data[15:0] write data
//   rd_data[15:0] combinational readback of the shadow registers
//   pwm_out_a     channel A PWM
//   pwm_out_b     channel B PWM
//   EN_PWM_OUTA0  mux enable for channel A (= CTRL[1])
//   EN_PWM_OUTB0  mux enable for channel B (= CTRL[2])
//   period_tick   one-cycle pulse the cycle after a counter wrap
// -----------------------------------------------------------------------------
module gpio_pwm_gen #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        pwm_out_a,
  output logic        pwm_out_b,
  output logic        EN_PWM_OUTA0,
  output logic        EN_PWM_OUTB0,
  output logic        period_tick
);

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PERIOD = 3'd1;
  localparam logic [2:0] ADDR_CMP_A  = 3'd2;
  localparam logic [2:0] ADDR_CMP_B  = 3'd3;

`ifdef GPIO_PWM_DEADTIME_EN
  localparam logic [2:0] ADDR_DEADTIME = 3'd4;
  localparam logic [5:0] CTRL_MASK     = 6'h3F;
`else
  localparam logic [5:0] CTRL_MASK     = 6'h1F;
`endif

  logic [5:0]       ctrl;
  logic [WIDTH-1:0] period_sh, period_act;
  logic [WIDTH-1:0] cmp_a_sh, cmp_a_act;
  logic [WIDTH-1:0] cmp_b_sh, cmp_b_act;
  logic [WIDTH-1:0] cnt;

  logic run, pol_a, pol_b;
  logic wrap, load_act;
  logic wr_period, wr_cmp_a, wr_cmp_b;
  logic raw_a_pre, raw_b_pre, raw_a, raw_b;

  assign run   = ctrl[0];
  assign pol_a = ctrl[3];
  assign pol_b = ctrl[4];

  assign EN_PWM_OUTA0 = ctrl[1];
  assign EN_PWM_OUTB0 = ctrl[2];

  // With period_act == 0 the count is already at its end, so every running
  // cycle is a wrap.
  assign wrap     = run & (cnt == period_act);
  // Active registers follow the shadows at each wrap and continuously when stopped.
  assign load_act = ~run | wrap;

  assign wr_period = wr_en & (addr == ADDR_PERIOD);
  assign wr_cmp_a  = wr_en & (addr == ADDR_CMP_A);
  assign wr_cmp_b  = wr_en & (addr == ADDR_CMP_B);

  // Unsigned compare: cmp == 0 never asserts, cmp > period_act always asserts.
  assign raw_a_pre = run & (cnt < cmp_a_act);
  assign raw_b_pre = run & (cnt < cmp_b_act);

`ifdef GPIO_PWM_DEADTIME_EN
  logic [7:0] deadtime_sh, deadtime_act, dt_cnt;
  logic       wr_deadtime, comp, raw_a_q, a_chg, dead;

  assign wr_deadtime = wr_en & (addr == ADDR_DEADTIME);
  assign comp        = ctrl[5];

  // Blanking covers the change cycle itself plus (DEADTIME-1) further cycles
  // held in dt_cnt; a new change reloads the count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    a_chg = 1'b0;
    dead  = 1'b0;
    raw_a = raw_a_pre;
    raw_b = raw_b_pre;
    if (comp) begin
      a_chg = (raw_a_pre != raw_a_q);
      dead  = (a_chg & (deadtime_act != 8'd0)) | (dt_cnt != 8'd0);
      raw_a = raw_a_pre & ~dead;
      raw_b = run & ~raw_a_pre & ~dead;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deadtime_sh  <= '0;
      deadtime_act <= '0;
      dt_cnt       <= '0;
      raw_a_q      <= 1'b0;
    end else begin
      if (wr_deadtime) deadtime_sh <= wr_data[7:0];
      if (load_act)    deadtime_act <= wr_deadtime ? wr_data[7:0] : deadtime_sh;
      raw_a_q <= raw_a_pre;
      if (!run || !comp)
        dt_cnt <= '0;
      else if (a_chg)
        dt_cnt <= (deadtime_act == 8'd0) ? 8'd0 : 8'(deadtime_act - 8'd1);
      else if (dt_cnt != 8'd0)
        dt_cnt <= 8'(dt_cnt - 8'd1);
    end
  end
`else
  assign raw_a = raw_a_pre;
  assign raw_b = raw_b_pre;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl        <= '0;
      period_sh   <= '0;
      period_act  <= '0;
      cmp_a_sh    <= '0;
      cmp_a_act   <= '0;
      cmp_b_sh    <= '0;
      cmp_b_act   <= '0;
      cnt         <= '0;
      period_tick <= 1'b0;
      pwm_out_a   <= 1'b0;
      pwm_out_b   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of its neighbours, independent of statement order.
      if (wr_en && addr == ADDR_CTRL) ctrl <= wr_data[5:0] & CTRL_MASK;
      if (wr_period) period_sh <= wr_data[WIDTH-1:0];
      if (wr_cmp_a)  cmp_a_sh  <= wr_data[WIDTH-1:0];
      if (wr_cmp_b)  cmp_b_sh  <= wr_data[WIDTH-1:0];

      if (load_act) begin
        period_act <= wr_period ? wr_data[WIDTH-1:0] : period_sh;
        cmp_a_act  <= wr_cmp_a  ? wr_data[WIDTH-1:0] : cmp_a_sh;
        cmp_b_act  <= wr_cmp_b  ? wr_data[WIDTH-1:0] : cmp_b_sh;
      end

      // Stopped or wrapping both return the counter to 0.
      cnt         <= load_act ? '0 : cnt + WIDTH'(1);
      period_tick <= wrap;
      // raw is 0 while stopped, so the outputs idle at their polarity level.
      pwm_out_a   <= raw_a ^ pol_a;
      pwm_out_b   <= raw_b ^ pol_b;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_CTRL:     rd_data = 16'(ctrl);
      ADDR_PERIOD:   rd_data = 16'(period_sh);
      ADDR_CMP_A:    rd_data = 16'(cmp_a_sh);
      ADDR_CMP_B:    rd_data = 16'(cmp_b_sh);
`ifdef GPIO_PWM_DEADTIME_EN
      ADDR_DEADTIME: rd_data = 16'(deadtime_sh);
`endif
      default:       rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_gpio_pwm_gen
//   Scoreboard bench for gpio_pwm_gen. A reference model, stepped on each
//   rising edge with the inputs the DUT sampled, pushes the expected outputs
//   into a queue; a monitor on the falling edge pops and compares them. The
//   model works in terms of "position within the PWM cycle" and "high time =
//   min(cmp, period+1)". Directed scenarios add independent duty/tick counts.
// -----------------------------------------------------------------------------
module tb_gpio_pwm_gen;

  localparam int WIDTH = 16;
  localparam int VMASK = (1 << WIDTH) - 1;
`ifdef GPIO_PWM_DEADTIME_EN
  localparam int CTRL_MASK = 'h3F;
  localparam bit HAS_DT    = 1'b1;
`else
  localparam int CTRL_MASK = 'h1F;
  localparam bit HAS_DT    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, wr_en;
  logic [2:0]  addr;
  logic [15:0] wr_data, rd_data;
  logic        pwm_out_a, pwm_out_b, EN_PWM_OUTA0, EN_PWM_OUTB0, period_tick;

  always #5 clk = ~clk;

  gpio_pwm_gen #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .pwm_out_a(pwm_out_a), .pwm_out_b(pwm_out_b),
    .EN_PWM_OUTA0(EN_PWM_OUTA0), .EN_PWM_OUTB0(EN_PWM_OUTB0),
    .period_tick(period_tick)
  );

  typedef struct packed {
    logic a, b, tick, en_a, en_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (register file view + cycle position).
  int m_ctrl, m_per_sh, m_cmpa_sh, m_cmpb_sh, m_dt_sh;
  int m_per, m_cmpa, m_cmpb, m_dt;
  int m_pos, m_since;
  bit m_prev_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_rd(input int a);
    case (a)
      0: return m_ctrl;
      1: return m_per_sh;
      2: return m_cmpa_sh;
      3: return m_cmpb_sh;
      4: return HAS_DT ? m_dt_sh : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    exp_t e;
    bit   run, wrap, load, comp, ra_pre, rb_pre, ra, rb, masked;
    int   hi_a, hi_b;
    bit   w;
    int   a, d;
    w = wr_en; a = addr; d = wr_data;
    if (!rst_n) begin
      m_ctrl = 0; m_per_sh = 0; m_cmpa_sh = 0; m_cmpb_sh = 0; m_dt_sh = 0;
      m_per = 0; m_cmpa = 0; m_cmpb = 0; m_dt = 0; m_pos = 0;
      m_since = 255; m_prev_a = 1'b0;
      e = '0;
    end else begin
      run  = m_ctrl[0];
      comp = m_ctrl[5];
      wrap = run && (m_pos == m_per);
      hi_a = (m_cmpa < m_per + 1) ? m_cmpa : m_per + 1;
      hi_b = (m_cmpb < m_per + 1) ? m_cmpb : m_per + 1;
      ra_pre = run && (m_pos < hi_a);
      rb_pre = run && (m_pos < hi_b);
      // Dead-time: cycles elapsed since raw A last changed.
      if (!run || !comp)           m_since = 255;
      else if (ra_pre != m_prev_a) m_since = 0;
      else if (m_since < 255)      m_since++;
      m_prev_a = ra_pre;
      masked = comp && (m_since < m_dt);
      if (comp) begin
        ra = ra_pre && !masked;
        rb = run && !ra_pre && !masked;
      end else begin
        ra = ra_pre;
        rb = rb_pre;
      end
      e.a    = ra ^ m_ctrl[3];
      e.b    = rb ^ m_ctrl[4];
      e.tick = wrap;
      load = !run || wrap;
      if (load) begin
        m_per  = (w && a == 1) ? (d & VMASK) : m_per_sh;
        m_cmpa = (w && a == 2) ? (d & VMASK) : m_cmpa_sh;
        m_cmpb = (w && a == 3) ? (d & VMASK) : m_cmpb_sh;
        if (HAS_DT) m_dt = (w && a == 4) ? (d & 'hFF) : m_dt_sh;
      end
      m_pos = load ? 0 : m_pos + 1;
      if (w) begin
        case (a)
          0: m_ctrl    = d & CTRL_MASK;
          1: m_per_sh  = d & VMASK;
          2: m_cmpa_sh = d & VMASK;
          3: m_cmpb_sh = d & VMASK;
          4: if (HAS_DT) m_dt_sh = d & 'hFF;
          default: ;
        endcase
      end
      e.en_a = m_ctrl[1];
      e.en_b = m_ctrl[2];
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pwm_out_a",    pwm_out_a,    e.a);
      check("pwm_out_b",    pwm_out_b,    e.b);
      check("period_tick",  period_tick,  e.tick);
      check("EN_PWM_OUTA0", EN_PWM_OUTA0, e.en_a);
      check("EN_PWM_OUTB0", EN_PWM_OUTB0, e.en_b);
      check("rd_data",      rd_data,      model_rd(addr));
    end
  end

  // ---------------- driver helpers (always resume #1 after a rising edge) ---
  task automatic tick_cycle();
    @(posedge clk);
    #1;
    addr = 3'($urandom_range(0, 7));
  endtask

  task automatic idle(input int n);
    repeat (n) tick_cycle();
  endtask

  task automatic write_reg(input int a, input int d);
    wr_en = 1'b1; addr = 3'(a); wr_data = 16'(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Returns in the cycle right after a period_tick cycle (counter at 1).
  task automatic sync_to_cycle();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (period_tick) seen = 1'b1;
    end
    check("sync_period_tick_seen", seen, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input int n, output int ha, output int hb, output int tk);
    ha = 0; hb = 0; tk = 0;
    repeat (n) begin
      @(negedge clk);
      ha += int'(pwm_out_a);
      hb += int'(pwm_out_b);
      tk += int'(period_tick);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int ha, hb, tk;
    rst_n = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;

    // T1 reset
    idle(2);
    @(negedge clk);
    check("reset_pwm_a", pwm_out_a, 1'b0);
    check("reset_pwm_b", pwm_out_b, 1'b0);
    check("reset_tick",  period_tick, 1'b0);
    for (int a = 0; a < 4; a++) begin
      addr = 3'(a);
      #1;
      check($sformatf("reset_rd_%0d", a), rd_data, 16'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T2 duty
    write_reg(1, 9);
    write_reg(2, 3);
    write_reg(0, 'h03);
    idle(12);
    measure(30, ha, hb, tk);
    check("t2_high_a", ha, 9);
    check("t2_high_b", hb, 0);
    check("t2_ticks",  tk, 3);
    check("t2_en_a",   EN_PWM_OUTA0, 1'b1);

    // T3 boundaries
    write_reg(2, 0);
    idle(12);
    measure(20, ha, hb, tk);
    check("t3_cmp0_high_a", ha, 0);
    write_reg(2, 10);
    idle(12);
    measure(20, ha, hb, tk);
    check("t3_cmp_gt_per_high_a", ha, 20);
    write_reg(1, 0);
    write_reg(2, 1);
    idle(15);
    measure(10, ha, hb, tk);
    check("t3_per0_high_a", ha, 10);
    check("t3_per0_ticks",  tk, 10);

    // T4 shadow: mid-cycle write, then write coinciding with wrap
    write_reg(1, 9);
    write_reg(2, 3);
    idle(25);
    sync_to_cycle();
    idle(3);
    write_reg(2, 7);
    sync_to_cycle();
    measure(10, ha, hb, tk);
    check("t4_next_cycle_duty7", ha, 7);
    sync_to_cycle();
    idle(8);
    write_reg(2, 2);
    @(posedge clk);
    #1;
    measure(10, ha, hb, tk);
    check("t4_wrap_write_duty2", ha, 2);

    // T5 polarity and stop
    write_reg(3, 2);
    write_reg(0, 'h17);
    idle(25);
    sync_to_cycle();
    measure(10, ha, hb, tk);
    check("t5_high_b_pol", hb, 8);
    sync_to_cycle();
    idle(4);
    write_reg(0, 'h16);
    idle(2);
    @(negedge clk);
    check("t5_stop_a", pwm_out_a, 1'b0);
    check("t5_stop_b", pwm_out_b, 1'b1);
    @(posedge clk);
    #1;

`ifdef GPIO_PWM_DEADTIME_EN
    // T6 complementary outputs with dead-time
    write_reg(0, 'h00);
    write_reg(1, 19);
    write_reg(2, 10);
    write_reg(3, 5);
    write_reg(4, 2);
    write_reg(0, 'h27);
    idle(30);
    sync_to_cycle();
    measure(20, ha, hb, tk);
    check("t6_high_a", ha, 8);
    check("t6_high_b", hb, 8);
`endif

    // Randomized register traffic, checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      int a, d;
      idle($urandom_range(0, 8));
      do a = $urandom_range(0, 7); while (HAS_DT && a == 4);
      case (a)
        0: d = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 63) | 1) : $urandom_range(0, 63);
        1: d = $urandom_range(0, 12);
        2, 3: d = $urandom_range(0, 15);
        default: d = $urandom_range(0, 65535);
      endcase
      write_reg(a, d);
    end
    idle(5);
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
